// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RISC-X core types, exception causes and LSU state encoding
package core_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } data_type_t;

  typedef enum logic [1:0] {
    X_REG   = 2'd0,
    F_REG   = 2'd1,
    CSR_REG = 2'd2
  } reg_bank_mux_t;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t LSU_IDLE        = 2'd0;
  localparam lsu_state_t LSU_WAIT_GNT    = 2'd1;
  localparam lsu_state_t LSU_WAIT_RVALID = 2'd2;
  localparam lsu_state_t LSU_DONE        = 2'd3;

  localparam logic [4:0] EXC_LOAD_MISALIGNED  = 5'd4;
  localparam logic [4:0] EXC_STORE_MISALIGNED = 5'd6;

  typedef struct packed {
    logic [4:0]    rd_addr;
    reg_bank_mux_t rd_dst_bank;
    logic [31:0]   alu_result;
    logic          mem_wen;
    logic          reg_mem_wen;
    logic          reg_alu_wen;
    data_type_t    data_type;
    logic          sign_ext;
    logic [31:0]   wdata;
    logic          valid;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_RESET = '{
    rd_addr:     5'd0,
    rd_dst_bank: X_REG,
    alu_result:  32'd0,
    mem_wen:     1'b0,
    reg_mem_wen: 1'b0,
    reg_alu_wen: 1'b0,
    data_type:   WORD,
    sign_ext:    1'b0,
    wdata:       32'd0,
    valid:       1'b0
  };

  function automatic logic [3:0] byte_enable(input data_type_t dt, input logic [1:0] off);
    logic [3:0] be;
    case (dt)
      BYTE:    be = 4'b0001 << off;
      HALF:    be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - shifts a load word down to its byte offset and zero/sign-extends it
module load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  data_type_t  data_type_i,
  input  logic        sign_ext_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (data_type_i)
      BYTE:    data_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
      HALF:    data_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-X memory-access stage: EX/MEM register, data-memory port and misalignment traps
module mem_stage
  import core_pkg::*;
#(
  parameter bit ISA_F = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic [4:0]    rd_addr_ex_i,
  input  reg_bank_mux_t rd_dst_bank_ex_i,
  input  logic [31:0]   alu_result_ex_i,
  input  logic          mem_wen_ex_i,
  input  logic          reg_mem_wen_ex_i,
  input  logic          reg_alu_wen_ex_i,
  input  data_type_t    mem_data_type_ex_i,
  input  logic          mem_sign_extend_ex_i,
  input  logic [31:0]   mem_wdata_ex_i,
  input  logic          valid_ex_i,

  input  logic          stall_mem_i,
  input  logic          flush_mem_i,

  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [31:0]   dmem_addr_o,
  output logic [3:0]    dmem_be_o,
  output logic [31:0]   dmem_wdata_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [31:0]   dmem_rdata_i,

  output logic [4:0]    rd_addr_mem_o,
  output reg_bank_mux_t rd_dst_bank_mem_o,
  output logic          reg_alu_wen_mem_o,
  output logic          reg_mem_wen_mem_o,
  output logic          valid_mem_o,
  output logic [31:0]   alu_result_mem_o,
  output logic [31:0]   mem_rdata_mem_o,
  output logic          lsu_busy_mem_o,
  output logic          trap_mem_o,
  output logic [4:0]    trap_cause_mem_o,
  output logic [31:0]   trap_addr_mem_o
);

  ex_mem_t     pipe_d, pipe_q;
  lsu_state_t  state_d, state_q;
  logic [31:0] rdata_d, rdata_q;

  logic        is_mem;
  logic        misaligned;
  logic        access;
  logic        take_ex;
  logic [1:0]  offset;
  logic [31:0] aligned_rdata;

  assign offset = pipe_q.alu_result[1:0];

  always_comb begin
    is_mem     = pipe_q.mem_wen | pipe_q.reg_mem_wen;
    misaligned = 1'b0;
    if (is_mem) begin
      case (pipe_q.data_type)
        HALF:    misaligned = offset[0];
        WORD:    misaligned = (offset != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
    access = pipe_q.valid & is_mem & ~misaligned;
  end

  always_comb begin
    lsu_busy_mem_o = 1'b0;
    if (access) begin
      case (state_q)
        LSU_IDLE, LSU_WAIT_GNT: lsu_busy_mem_o = 1'b1;
        LSU_WAIT_RVALID:        lsu_busy_mem_o = ~dmem_rvalid_i;
        default:                lsu_busy_mem_o = 1'b0;
      endcase
    end
  end

  // While a bus transaction is in flight the instruction must stay put, even if the controller lets go.
  assign take_ex = ~stall_mem_i & ~lsu_busy_mem_o;

  always_comb begin
    pipe_d = pipe_q;
    if (take_ex) begin
      if (flush_mem_i) begin
        pipe_d.mem_wen     = 1'b0;
        pipe_d.reg_mem_wen = 1'b0;
        pipe_d.reg_alu_wen = 1'b0;
        pipe_d.valid       = 1'b0;
      end else begin
        pipe_d.rd_addr     = rd_addr_ex_i;
        pipe_d.rd_dst_bank = ISA_F ? rd_dst_bank_ex_i : X_REG;
        pipe_d.alu_result  = alu_result_ex_i;
        pipe_d.mem_wen     = mem_wen_ex_i;
        pipe_d.reg_mem_wen = reg_mem_wen_ex_i;
        pipe_d.reg_alu_wen = reg_alu_wen_ex_i;
        pipe_d.data_type   = mem_data_type_ex_i;
        pipe_d.sign_ext    = mem_sign_extend_ex_i;
        pipe_d.wdata       = mem_wdata_ex_i;
        pipe_d.valid       = valid_ex_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: begin
        if (access) state_d = dmem_gnt_i ? LSU_WAIT_RVALID : LSU_WAIT_GNT;
      end
      LSU_WAIT_GNT: begin
        if (dmem_gnt_i) state_d = LSU_WAIT_RVALID;
      end
      LSU_WAIT_RVALID: begin
        if (dmem_rvalid_i) state_d = stall_mem_i ? LSU_DONE : LSU_IDLE;
      end
      default: begin
        if (!stall_mem_i) state_d = LSU_IDLE;
      end
    endcase
  end

  load_align u_load_align (
    .rdata_i     (dmem_rdata_i),
    .offset_i    (offset),
    .data_type_i (pipe_q.data_type),
    .sign_ext_i  (pipe_q.sign_ext),
    .data_o      (aligned_rdata)
  );

  // Store responses also return rvalid; only loads refresh the held read data.
  always_comb begin
    rdata_d = rdata_q;
    if (state_q == LSU_WAIT_RVALID && dmem_rvalid_i && pipe_q.reg_mem_wen) begin
      rdata_d = aligned_rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q  <= EX_MEM_RESET;
      state_q <= LSU_IDLE;
      rdata_q <= 32'd0;
    end else begin
      pipe_q  <= pipe_d;
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign dmem_req_o   = access & ((state_q == LSU_IDLE) | (state_q == LSU_WAIT_GNT));
  assign dmem_we_o    = pipe_q.mem_wen;
  assign dmem_addr_o  = {pipe_q.alu_result[31:2], 2'b00};
  assign dmem_be_o    = byte_enable(pipe_q.data_type, offset);
  assign dmem_wdata_o = pipe_q.wdata << {offset, 3'b000};

  assign rd_addr_mem_o     = pipe_q.rd_addr;
  assign rd_dst_bank_mem_o = pipe_q.rd_dst_bank;
  assign reg_alu_wen_mem_o = pipe_q.reg_alu_wen;
  assign reg_mem_wen_mem_o = pipe_q.reg_mem_wen & ~misaligned;
  assign valid_mem_o       = pipe_q.valid;
  assign alu_result_mem_o  = pipe_q.alu_result;
  assign mem_rdata_mem_o   = rdata_q;

  assign trap_mem_o       = pipe_q.valid & misaligned;
  assign trap_cause_mem_o = trap_mem_o ? (pipe_q.mem_wen ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED) : 5'd0;
  assign trap_addr_mem_o  = trap_mem_o ? pipe_q.alu_result : 32'd0;

endmodule
